// File: rtl/ks_serial_adder.sv
// ks_serial_adder: digit-serial WIDTH-bit adder built on a 4-bit Kogge-Stone core.
// One 4-bit digit is added per cycle, LSB first, and the carry is chained in a register.
// Optional feature macro: KS_SERIAL_OVF_EN adds the signed-overflow output ovf.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload stable
// until that edge. The consumer may drive ready independently of valid.
//
// WIDTH must be a multiple of 4 and at least 4.

// 4-bit Kogge-Stone adder: two prefix levels (spans 1 and 2), no carry-in.
module kogge_stone_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] SUM,
  output logic       Cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] g1;
  logic [1:0] p1;
  logic [3:0] g2;

  assign g = A & B;
  assign p = A ^ B;

  // Level 1: combine each bit with its neighbour one position down.
  assign g1[0]   = g[0];
  assign g1[3:1] = g[3:1] | (p[3:1] & g[2:0]);
  // Only bits 3:2 need group-propagate for the next level.
  assign p1      = p[3:2] & p[2:1];

  // Level 2: combine with the group two positions down.
  assign g2[1:0] = g1[1:0];
  assign g2[3:2] = g1[3:2] | (p1 & g1[1:0]);

  // Carry into bit i is the group generate of bits i-1..0.
  assign SUM  = p ^ {g2[2:0], 1'b0};
  assign Cout = g2[3];
endmodule

module ks_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
`ifdef KS_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int D  = WIDTH / 4;
  localparam int CW = $clog2(D) + 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
`ifdef KS_SERIAL_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [3:0]       s1, s2;
  logic             c1, c2;
  logic             digit_carry;
  logic [WIDTH-1:0] sum_sh_next;

  // First core adds the current operand digits; second folds in the chained carry.
  kogge_stone_4bit u_core0 (
    .A    (a_sh_q[3:0]),
    .B    (b_sh_q[3:0]),
    .SUM  (s1),
    .Cout (c1)
  );

  kogge_stone_4bit u_core1 (
    .A    (s1),
    .B    ({3'b000, carry_q}),
    .SUM  (s2),
    .Cout (c2)
  );

  // c1 and c2 are mutually exclusive, so OR gives the digit's carry-out.
  assign digit_carry = c1 | c2;
  // New digit enters at the top; after D shifts the sum is LSB-aligned.
  assign sum_sh_next = (sum_sh_q >> 4) | (WIDTH'(s2) << (WIDTH - 4));

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef KS_SERIAL_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef KS_SERIAL_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        sum_sh_d = sum_sh_next;
        carry_d  = digit_carry;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = sum_sh_next;
          cout_d  = digit_carry;
`ifdef KS_SERIAL_OVF_EN
          ovf_d   = (a_msb_q == b_msb_q) && (sum_sh_next[WIDTH-1] != a_msb_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  // All state and result registers; async reset discards any in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef KS_SERIAL_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef KS_SERIAL_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;
`ifdef KS_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_ks_serial_adder.sv
// Bench for ks_serial_adder: WIDTH=16 instance checked against a plain-arithmetic
// model on every result cycle, plus a WIDTH=4 instance checked exhaustively.
`timescale 1ns/1ps
module tb_ks_serial_adder;
  localparam int W = 16;
  localparam int D = W / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (WIDTH=16) ----------------
  logic         in_valid, in_ready, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
  logic [1:0]   dbg_state;
`ifdef KS_SERIAL_OVF_EN
  logic         ovf;
`endif

  ks_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
`ifdef KS_SERIAL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- DUT (WIDTH=4) ----------------
  logic       in_valid4, in_ready4, out_valid4, out_ready4, cout4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] dbg_state4;
`ifdef KS_SERIAL_OVF_EN
  logic       ovf4;
`endif

  ks_serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .dbg_state (dbg_state4)
`ifdef KS_SERIAL_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  // ---------------- model ----------------
  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W:0] r;
    r = $signed({x[W-1], x}) + $signed({y[W-1], y});
    return (r > $signed((W+1)'(2**(W-1) - 1))) || (r < -$signed((W+1)'(2**(W-1))));
  endfunction

  function automatic logic [4:0] model_add4(input logic [3:0] x, input logic [3:0] y);
    return 5'(int'(x) + int'(y));
  endfunction

  function automatic logic model_ovf4(input logic [3:0] x, input logic [3:0] y);
    int r;
    r = int'($signed(x)) + int'($signed(y));
    return (r > 7) || (r < -8);
  endfunction

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  logic       exp_ovf_q[$];
  int         acc_cyc  = 0;
  int         done_cnt = 0;
  logic       ov_prev  = 1'b0;

  // Compare process: records accepted pairs and checks every cycle a result is shown.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_out_valid");
        end else begin
          e = exp_q[0];
          check("sum", 64'(sum), 64'(e[W-1:0]));
          check("cout", 64'(cout), 64'(e[W]));
`ifdef KS_SERIAL_OVF_EN
          check("ovf", 64'(ovf), 64'(exp_ovf_q[0]));
`endif
          if (!ov_prev) check("latency", 64'(cyc - acc_cyc), 64'(D + 1));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_ovf_q.pop_front());
            done_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_add(a, b));
        exp_ovf_q.push_back(model_ovf(a, b));
        acc_cyc = cyc;
      end
      ov_prev = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) fail_now("send_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin @(negedge clk); n++; end
    if (done_cnt < target) fail_now("result_timeout");
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int target;
    target = done_cnt + 1;
    send(x, y);
    wait_result(target);
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y);
    int n;
    logic [4:0] e;
    @(posedge clk); #1;
    in_valid4 = 1'b1; a4 = x; b4 = y;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready4 && n < 50);
    if (!in_ready4) fail_now("send4_timeout");
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      n++;
      @(negedge clk);
    end while (!out_valid4 && n < 20);
    e = model_add4(x, y);
    check("lat4", 64'(n), 64'(2));
    check("sum4", 64'(sum4), 64'(e[3:0]));
    check("cout4", 64'(cout4), 64'(e[4]));
`ifdef KS_SERIAL_OVF_EN
    check("ovf4", 64'(ovf4), 64'(model_ovf4(x, y)));
`endif
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[12] = '{
    '{16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1},
    '{16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1},
    '{16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0},
    '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0},
    '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0},
    '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0},
    '{16'h0F0F, 16'hF0F1, 16'h0000, 1'b1, 1'b0},
    '{16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1},
    '{16'h4000, 16'h4000, 16'h8000, 1'b0, 1'b1},
    '{16'h9ABC, 16'h1357, 16'hAE13, 1'b0, 1'b0}
  };

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int t[3];
    int target;
    logic [W:0] m;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    check("rst_in_ready4", 64'(in_ready4), 64'(0));
    check("rst_state4", 64'(dbg_state4), 64'(0));
`ifdef KS_SERIAL_OVF_EN
    check("rst_ovf", 64'(ovf), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Pin the model against hand-computed results
    m = model_add(16'h00FF, 16'h0001);
    check("model_00ff", 64'(m), 64'(17'h00100));
    m = model_add(16'hFFFF, 16'h0001);
    check("model_ffff", 64'(m), 64'(17'h10000));
    check("model_ovf_7fff", 64'(model_ovf(16'h7FFF, 16'h0001)), 64'(1));
    check("model_ovf_1234", 64'(model_ovf(16'h1234, 16'h4321)), 64'(0));
    check("model4_ff", 64'(model_add4(4'hF, 4'hF)), 64'(5'h1E));

    // Directed vectors with literal expectations (model checks run alongside)
    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].c));
`ifdef KS_SERIAL_OVF_EN
      check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].v));
`endif
    end

    // Throughput: in_valid held high, out_ready high -> one op every D+2 cycles
    target = done_cnt + 3;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h0011; b = 16'h0022;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 100);
      if (!in_ready) fail_now("stream_timeout");
      t[i] = cyc;
      @(posedge clk); #1;
      a = a + 16'h1000; b = b + 16'h0300;
    end
    in_valid = 1'b0;
    wait_result(target);
    check("throughput_gap0", 64'(t[1] - t[0]), 64'(D + 2));
    check("throughput_gap1", 64'(t[2] - t[1]), 64'(D + 2));

    // Backpressure: DONE held 10 cycles with a new pair waiting
    target = done_cnt + 2;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h1111, 16'h2222);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      if (!out_valid) fail_now("bp_wait_valid");
    end
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h0101; b = 16'h0202;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_sum", 64'(sum), 64'(16'h3333));
      check("bp_cout", 64'(cout), 64'(0));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_no_bypass", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("bp_idle_after", 64'(in_ready), 64'(1));
    check("bp_out_valid_low", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(target);
    check("bp_new_sum", 64'(sum), 64'(16'h0303));

    // Reset mid-operation during digit 2 of 0xFFFF + 0x0001
    send(16'hFFFF, 16'h0001);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_ovf_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_result", 64'(out_valid), 64'(0));
    end
    run_op(16'h0001, 16'h0002);
    check("post_rst_sum", 64'(sum), 64'(16'h0003));
    check("post_rst_cout", 64'(cout), 64'(0));

    // WIDTH=4 instance: hand-computed case, then every operand pair
    op4(4'hF, 4'hF);
    check("w4_lit_sum", 64'(sum4), 64'(4'hE));
    check("w4_lit_cout", 64'(cout4), 64'(1));
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j));
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
